// File: rtl/arm_mem_pkg.sv
// Shared types and default sizing for the arm_memory streaming blocks.
package arm_mem_pkg;

  // Reader sequencing states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } rd_state_e;

  localparam int DEF_ADDR_W     = 32;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_CNT_W      = 16;
  localparam int DEF_RD_LAT     = 1;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_ADDR_STEP  = 1;

  // Layout of one output-buffer entry at the default data width; the reader
  // packs {data, last} in the same order for any DATA_W.
  typedef struct packed {
    logic [DEF_DATA_W-1:0] data;
    logic                  last;
  } fifo_entry_t;

endpackage

// File: rtl/arm_stream_fifo.sv
// Synchronous power-of-two FIFO with occupancy count. Output is zero while empty.
module arm_stream_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 33,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             full_s;
  logic             empty_s;
  logic             do_push_s;
  logic             do_pop_s;

  assign full_s    = (count_r == CW'(DEPTH));
  assign empty_s   = (count_r == {CW{1'b0}});
  assign do_push_s = push & ~full_s;
  assign do_pop_s  = pop & ~empty_s;

  assign full     = full_s;
  assign empty    = empty_s;
  assign count    = count_r;
  assign pop_data = empty_s ? {WIDTH{1'b0}} : mem_r[rd_ptr_r];

  // Storage write; contents need no reset because reads are gated by empty
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping; simultaneous push and pop both take effect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  arm_stream_fifo_chk u_chk (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .full  (full_s)
  );

endmodule

// File: rtl/arm_stream_fifo_chk.sv
// Protocol checker for arm_stream_fifo: a push must never target a full buffer.
module arm_stream_fifo_chk (
  input logic clk,
  input logic rst_n,
  input logic push,
  input logic full
);

  a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n) !(push && full));

endmodule

// File: rtl/arm_mem_reader.sv
// Read-side streaming engine: sweeps a word range on memory port 1 under
// credit control and streams the returned words out on valid/ready.
module arm_mem_reader
  import arm_mem_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int RD_LAT     = DEF_RD_LAT,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int ADDR_STEP  = DEF_ADDR_STEP
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] err_addr,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              mem_excpt,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last
);

  localparam int CW      = $clog2(FIFO_DEPTH) + 1;
  localparam int ENTRY_W = DATA_W + 1;

  rd_state_e         state_r;
  rd_state_e         state_next_s;
  logic [ADDR_W-1:0] addr_r;
  logic [CNT_W-1:0]  remaining_r;
  logic              busy_r;
  logic              done_r;
  logic              err_r;
  logic [ADDR_W-1:0] err_addr_r;
  logic [RD_LAT-1:0] pipe_vld_r;
  logic [RD_LAT-1:0] pipe_last_r;
  logic [ADDR_W-1:0] pipe_addr_r [RD_LAT];

  logic [CW-1:0]      fifo_count_s;
  logic [CW-1:0]      inflight_s;
  logic [CW:0]        used_s;
  logic               fifo_full_s;
  logic               fifo_empty_s;
  logic               credit_s;
  logic               accept_s;
  logic               issue_s;
  logic               ret_vld_s;
  logic               ret_excpt_s;
  logic               push_s;
  logic [ENTRY_W-1:0] push_entry_s;
  logic [ENTRY_W-1:0] pop_entry_s;

  // Number of reads currently travelling through the latency pipe
  always_comb begin
    inflight_s = {CW{1'b0}};
    for (int i = 0; i < RD_LAT; i++) begin
      inflight_s = inflight_s + {{(CW-1){1'b0}}, pipe_vld_r[i]};
    end
  end

  // Credit counts both buffered and in-flight words so the FIFO can never overflow
  assign used_s      = {1'b0, fifo_count_s} + {1'b0, inflight_s};
  assign credit_s    = (used_s < (CW+1)'(FIFO_DEPTH));
  assign ret_vld_s   = pipe_vld_r[RD_LAT-1];
  assign ret_excpt_s = ret_vld_s & mem_excpt;
  assign push_s      = ret_vld_s & ~mem_excpt;
  assign accept_s    = (state_r == IDLE) & start;
  assign issue_s     = (state_r == ISSUE) & credit_s & ~fifo_full_s & ~ret_excpt_s;

  // Next-state selection
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          if (word_count == {CNT_W{1'b0}}) state_next_s = FINISH;
          else                             state_next_s = ISSUE;
        end else begin
          state_next_s = IDLE;
        end
      end
      ISSUE: begin
        if (ret_excpt_s)                                  state_next_s = DRAIN;
        else if (issue_s && (remaining_r == CNT_W'(1)))   state_next_s = DRAIN;
        else                                              state_next_s = ISSUE;
      end
      DRAIN: begin
        if ((inflight_s == {CW{1'b0}}) && fifo_empty_s) state_next_s = FINISH;
        else                                            state_next_s = DRAIN;
      end
      FINISH:  state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State, address sweep, status flags and error capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      addr_r      <= {ADDR_W{1'b0}};
      remaining_r <= {CNT_W{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      err_addr_r  <= {ADDR_W{1'b0}};
    end else begin
      state_r <= state_next_s;
      busy_r  <= (state_next_s == ISSUE) || (state_next_s == DRAIN);
      done_r  <= (state_next_s == FINISH);
      if (accept_s) begin
        addr_r      <= base_addr;
        remaining_r <= word_count;
      end else if (issue_s) begin
        addr_r      <= addr_r + ADDR_W'(ADDR_STEP);
        remaining_r <= remaining_r - CNT_W'(1);
      end
      if (accept_s) begin
        err_r <= 1'b0;
      end else if (ret_excpt_s) begin
        err_r      <= 1'b1;
        err_addr_r <= pipe_addr_r[RD_LAT-1];
      end
    end
  end

  // Latency pipe tracking valid/last/address of each outstanding read; an
  // exception flushes it so later returns of the aborted sweep are dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld_r  <= {RD_LAT{1'b0}};
      pipe_last_r <= {RD_LAT{1'b0}};
      for (int i = 0; i < RD_LAT; i++) pipe_addr_r[i] <= {ADDR_W{1'b0}};
    end else begin
      for (int i = RD_LAT-1; i > 0; i--) begin
        pipe_vld_r[i]  <= pipe_vld_r[i-1] & ~ret_excpt_s;
        pipe_last_r[i] <= pipe_last_r[i-1];
        pipe_addr_r[i] <= pipe_addr_r[i-1];
      end
      pipe_vld_r[0]  <= issue_s;
      pipe_last_r[0] <= (remaining_r == CNT_W'(1));
      pipe_addr_r[0] <= addr_r;
    end
  end

  assign push_entry_s = {mem_data, pipe_last_r[RD_LAT-1]};

  arm_stream_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_s),
    .push_data (push_entry_s),
    .pop       (m_ready),
    .pop_data  (pop_entry_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (fifo_count_s)
  );

  assign busy     = busy_r;
  assign done     = done_r;
  assign err      = err_r;
  assign err_addr = err_addr_r;
  assign mem_addr = addr_r;
  assign m_valid  = ~fifo_empty_s;
  assign m_data   = pop_entry_s[ENTRY_W-1:1];
  assign m_last   = pop_entry_s[0];

endmodule

// File: tb/tb_arm_mem_reader.sv
// Directed bench for arm_mem_reader with a one-cycle-latency memory model.
module tb_arm_mem_reader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] base_addr;
  logic [15:0] word_count;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] err_addr;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        mem_excpt;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic        m_last;

  logic [31:0] mem [64];
  logic        excpt_en;
  logic [31:0] excpt_addr;

  int pass_cnt;
  int total_cnt;

  logic [31:0] beat_data [$];
  logic        beat_last [$];
  int          beat_idx  [$];
  int          done_cnt;
  int          stall_err;
  int          max_ahead;
  int          valid_cnt;

  arm_mem_reader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .err_addr   (err_addr),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_excpt  (mem_excpt),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory port 1 model: registered read, one cycle of latency
  always @(posedge clk) begin
    mem_data  <= mem[mem_addr[5:0]];
    mem_excpt <= excpt_en && (mem_addr == excpt_addr);
  end

  // Run one transfer, recording accepted beats, done pulses and stall behaviour
  task automatic run_xfer(input logic [31:0] b, input logic [15:0] n, input int mode, input int restart_idx);
    int idx;
    int done_idx;
    int ahead;
    logic prev_stall;
    logic [31:0] prev_data;
    logic prev_last;
    beat_data.delete();
    beat_last.delete();
    beat_idx.delete();
    done_cnt = 0; stall_err = 0; max_ahead = 0; valid_cnt = 0;
    @(negedge clk);
    base_addr = b; word_count = n; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    idx = 0; done_idx = -1; prev_stall = 1'b0; prev_data = 32'h0; prev_last = 1'b0;
    while (idx < 200 && (done_idx < 0 || idx < done_idx + 4)) begin
      start   = (idx == restart_idx);
      m_ready = (mode == 0) ? 1'b1 : ((idx % 4 == 0) || (idx % 4 == 3));
      if (prev_stall && (!m_valid || m_data !== prev_data || m_last !== prev_last)) stall_err++;
      if (m_valid) valid_cnt++;
      ahead = int'(mem_addr - b) - beat_data.size();
      if (ahead > max_ahead) max_ahead = ahead;
      if (m_valid && m_ready) begin
        beat_data.push_back(m_data);
        beat_last.push_back(m_last);
        beat_idx.push_back(idx);
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
      if (done) begin
        done_cnt++;
        if (done_idx < 0) done_idx = idx;
      end
      @(negedge clk);
      idx++;
    end
    start   = 1'b0;
    m_ready = 1'b1;
  endtask

  task automatic test_reset;
    total_cnt++;
    if ({busy, done, err, m_valid, m_last, err_addr, mem_addr, m_data} !== 100'h0) begin
      $display("FAIL reset_outputs: got busy=%0b done=%0b err=%0b m_valid=%0b m_last=%0b err_addr=%h mem_addr=%h m_data=%h, want all 0",
               busy, done, err, m_valid, m_last, err_addr, mem_addr, m_data);
    end else pass_cnt++;
  endtask

  task automatic test_basic_dump;
    logic [31:0] got_d;
    logic        got_l;
    run_xfer(32'h0, 16'd8, 0, -1);
    for (int i = 0; i < 8; i++) begin
      got_d = (i < beat_data.size()) ? beat_data[i] : 32'hDEAD_DEAD;
      got_l = (i < beat_last.size()) ? beat_last[i] : 1'bx;
      total_cnt++;
      if (got_d !== 32'h1000 + 32'(i) || got_l !== (i == 7)) begin
        $display("FAIL basic_beat%0d: got data=%h last=%0b, want data=%h last=%0b", i, got_d, got_l, 32'h1000 + 32'(i), (i == 7));
      end else pass_cnt++;
    end
    total_cnt++;
    if (beat_data.size() != 8 || beat_idx[0] != 2 || beat_idx[beat_idx.size()-1] != 9) begin
      $display("FAIL basic_timing: got beats=%0d first_cycle=%0d last_cycle=%0d, want 8 beats on cycles 2..9",
               beat_data.size(), (beat_idx.size() > 0) ? beat_idx[0] : -1, (beat_idx.size() > 0) ? beat_idx[beat_idx.size()-1] : -1);
    end else pass_cnt++;
    total_cnt++;
    if (done_cnt != 1 || busy !== 1'b0 || err !== 1'b0) begin
      $display("FAIL basic_done: got done_pulses=%0d busy=%0b err=%0b, want 1/0/0", done_cnt, busy, err);
    end else pass_cnt++;
  endtask

  task automatic test_backpressure;
    int bad;
    run_xfer(32'h0, 16'd8, 1, -1);
    bad = 0;
    for (int i = 0; i < beat_data.size(); i++) begin
      if (beat_data[i] !== 32'h1000 + 32'(i) || beat_last[i] !== (i == 7)) bad++;
    end
    total_cnt++;
    if (beat_data.size() != 8 || bad != 0) begin
      $display("FAIL bp_order: got beats=%0d misordered=%0d, want 8 beats 0x1000..0x1007 in order", beat_data.size(), bad);
    end else pass_cnt++;
    total_cnt++;
    if (stall_err != 0) begin
      $display("FAIL bp_stable: got %0d unstable stall cycles, want 0", stall_err);
    end else pass_cnt++;
    total_cnt++;
    if (max_ahead > 4) begin
      $display("FAIL bp_ahead: got max issue lead %0d, want <= 4", max_ahead);
    end else pass_cnt++;
    total_cnt++;
    if (done_cnt != 1) begin
      $display("FAIL bp_done: got done_pulses=%0d, want 1", done_cnt);
    end else pass_cnt++;
  endtask

  task automatic test_zero_length;
    run_xfer(32'h10, 16'd0, 0, -1);
    total_cnt++;
    if (done_cnt != 1 || valid_cnt != 0 || err !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL zero_len: got done_pulses=%0d valid_cycles=%0d err=%0b busy=%0b, want 1/0/0/0", done_cnt, valid_cnt, err, busy);
    end else pass_cnt++;
  endtask

  task automatic test_exception;
    int bad;
    int lasts;
    excpt_en = 1'b1; excpt_addr = 32'h5;
    run_xfer(32'h0, 16'd8, 0, -1);
    excpt_en = 1'b0;
    bad = 0; lasts = 0;
    for (int i = 0; i < beat_data.size(); i++) begin
      if (beat_data[i] !== 32'h1000 + 32'(i)) bad++;
      if (beat_last[i] !== 1'b0) lasts++;
    end
    total_cnt++;
    if (beat_data.size() != 5 || bad != 0) begin
      $display("FAIL excpt_words: got beats=%0d wrong=%0d, want 5 beats 0x1000..0x1004", beat_data.size(), bad);
    end else pass_cnt++;
    total_cnt++;
    if (lasts != 0) begin
      $display("FAIL excpt_nolast: got %0d beats with last, want 0", lasts);
    end else pass_cnt++;
    total_cnt++;
    if (err !== 1'b1 || err_addr !== 32'h5 || done_cnt != 1) begin
      $display("FAIL excpt_err: got err=%0b err_addr=%h done_pulses=%0d, want 1/00000005/1", err, err_addr, done_cnt);
    end else pass_cnt++;
    run_xfer(32'h0, 16'd1, 0, -1);
    total_cnt++;
    if (err !== 1'b0 || beat_data.size() != 1 || beat_data[0] !== 32'h1000 || beat_last[0] !== 1'b1) begin
      $display("FAIL excpt_clear: got err=%0b beats=%0d, want err=0 and one beat 0x1000 with last", err, beat_data.size());
    end else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    int idx;
    bit hit;
    @(negedge clk);
    base_addr = 32'h0; word_count = 16'd8; start = 1'b1; m_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    idx = 0; hit = 1'b0;
    while (idx < 50 && !hit) begin
      if (m_valid && m_data === 32'h1003) hit = 1'b1;
      else begin
        @(negedge clk);
        idx++;
      end
    end
    total_cnt++;
    if (!hit) begin
      $display("FAIL rstmid_reach: word 3 not presented within 50 cycles");
    end else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({busy, done, err, m_valid, m_last, err_addr, mem_addr, m_data} !== 100'h0) begin
      $display("FAIL rstmid_async: got busy=%0b done=%0b m_valid=%0b mem_addr=%h m_data=%h, want all 0",
               busy, done, m_valid, mem_addr, m_data);
    end else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (busy !== 1'b0 || m_valid !== 1'b0 || done !== 1'b0) begin
      $display("FAIL rstmid_release: got busy=%0b m_valid=%0b done=%0b, want 0/0/0", busy, m_valid, done);
    end else pass_cnt++;
    run_xfer(32'h20, 16'd2, 0, -1);
    total_cnt++;
    if (beat_data.size() != 2 || beat_data[0] !== 32'h1020 || beat_data[1] !== 32'h1021 ||
        beat_last[0] !== 1'b0 || beat_last[1] !== 1'b1 || done_cnt != 1) begin
      $display("FAIL rstmid_restart: got beats=%0d done_pulses=%0d, want 0x1020,0x1021(last) and 1 done", beat_data.size(), done_cnt);
    end else pass_cnt++;
  endtask

  task automatic test_wrap_busy_start;
    logic [31:0] exp [4];
    int bad;
    exp[0] = 32'h103E; exp[1] = 32'h103F; exp[2] = 32'h1000; exp[3] = 32'h1001;
    run_xfer(32'hFFFF_FFFE, 16'd4, 0, 2);
    bad = 0;
    for (int i = 0; i < beat_data.size() && i < 4; i++) begin
      if (beat_data[i] !== exp[i] || beat_last[i] !== (i == 3)) bad++;
    end
    total_cnt++;
    if (beat_data.size() != 4 || bad != 0) begin
      $display("FAIL wrap_data: got beats=%0d wrong=%0d, want 0x103E,0x103F,0x1000,0x1001(last)", beat_data.size(), bad);
    end else pass_cnt++;
    total_cnt++;
    if (done_cnt != 1 || busy !== 1'b0 || m_valid !== 1'b0) begin
      $display("FAIL wrap_ignore_start: got done_pulses=%0d busy=%0b m_valid=%0b, want 1/0/0", done_cnt, busy, m_valid);
    end else pass_cnt++;
  endtask

  initial begin
    pass_cnt = 0; total_cnt = 0;
    rst_n = 1'b0; start = 1'b0; base_addr = 32'h0; word_count = 16'h0; m_ready = 1'b1;
    excpt_en = 1'b0; excpt_addr = 32'h0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h1000 + 32'(i);
    repeat (3) @(negedge clk);
    test_reset;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    test_basic_dump;
    test_backpressure;
    test_zero_length;
    test_exception;
    test_reset_mid;
    test_wrap_busy_start;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
